// File: rtl/handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : handshake_fifo_buffer
// Brief    : Elastic FIFO with registered valid/ready/data and no bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          ins,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  output logic [DATA_WIDTH-1:0]          outs,
  output logic                           outs_valid,
  input  logic                           outs_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
);

  localparam int c_PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(NUM_SLOTS - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
  logic [c_PTR_W-1:0]    r_wp;
  logic [c_PTR_W-1:0]    r_rp;
  logic [c_CNT_W-1:0]    r_count;
  logic                  w_push;
  logic                  w_pop;

  // Handshake signals derive only from the registered count.
  assign ins_ready  = (r_count != c_FULL_CNT);
  assign outs_valid = (r_count != '0);
  assign outs       = outs_valid ? r_mem[r_rp] : '0;
  assign occupancy  = r_count;

  assign w_push = ins_valid & ins_ready;
  assign w_pop  = outs_valid & outs_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= ins;
    end
  end

  // Pointers wrap by explicit compare so any depth >= 2 is legal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= (r_wp == c_LAST_PTR) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= (r_rp == c_LAST_PTR) ? '0 : r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_fifo_buffer
// Brief    : Scoreboard bench for handshake_fifo_buffer (depth 4 and depth 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] ins4 = '0;
  logic        iv4 = 1'b0;
  logic        ir4;
  logic [31:0] outs4;
  logic        ov4;
  logic        or4 = 1'b0;
  logic [2:0]  occ4;

  logic [31:0] ins3 = '0;
  logic        iv3 = 1'b0;
  logic        ir3;
  logic [31:0] outs3;
  logic        ov3;
  logic        or3 = 1'b0;
  logic [1:0]  occ3;

  int n_tests = 0;
  int n_fail  = 0;
  int popped4 = 0;
  int popped3 = 0;
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(iv4), .ins_ready(ir4),
    .outs(outs4), .outs_valid(ov4), .outs_ready(or4), .occupancy(occ4)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(iv3), .ins_ready(ir3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(or3), .occupancy(occ3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted tokens, compare every pop in order.
  always @(negedge clk) begin
    if (!rst) begin
      q4.delete();
      q3.delete();
    end else begin
      if (ov4 && or4) begin
        if (q4.size() == 0) check("dut4 unexpected pop", outs4, 32'hDEAD_BEEF);
        else check("dut4 pop order", outs4, q4.pop_front());
        popped4++;
      end
      if (ov3 && or3) begin
        if (q3.size() == 0) check("dut3 unexpected pop", outs3, 32'hDEAD_BEEF);
        else check("dut3 pop order", outs3, q3.pop_front());
        popped3++;
      end
      if (iv4 && ir4) q4.push_back(ins4);
      if (iv3 && ir3) q3.push_back(ins3);
      if (occ3 > 2'd3) check("dut3 occupancy bound", 32'(occ3), 32'd3);
    end
  end

  initial begin
    int d;
    int cycles;
    logic acc;

    // Reset
    step();
    step();
    check("reset outs_valid", 32'(ov4), 32'd0);
    check("reset ins_ready", 32'(ir4), 32'd1);
    check("reset occupancy", 32'(occ4), 32'd0);
    check("reset outs", outs4, 32'd0);
    rst = 1'b1;

    // Single token
    ins4 = 32'h05A6715F; iv4 = 1'b1; or4 = 1'b1;
    check("single push-cycle outs_valid", 32'(ov4), 32'd0);
    step();
    iv4 = 1'b0;
    check("single outs_valid", 32'(ov4), 32'd1);
    check("single outs", outs4, 32'h05A6715F);
    check("single occupancy", 32'(occ4), 32'd1);
    step();
    check("single drained", 32'(ov4), 32'd0);

    // Fill to full
    or4 = 1'b0; iv4 = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      ins4 = 32'(t);
      check("fill ins_ready", 32'(ir4), 32'd1);
      step();
      check("fill outs head", outs4, 32'd1);
    end
    ins4 = 32'd5;
    check("full ins_ready", 32'(ir4), 32'd0);
    check("full occupancy", 32'(occ4), 32'd4);
    step();
    step();
    check("full hold occupancy", 32'(occ4), 32'd4);
    check("full hold outs", outs4, 32'd1);

    // Drain with concurrent push: first pop cycle refuses the push
    or4 = 1'b1;
    step();
    check("drain first occupancy", 32'(occ4), 32'd3);
    check("drain first ins_ready", 32'(ir4), 32'd1);
    check("drain first outs", outs4, 32'd2);
    for (int t = 6; t <= 9; t++) begin
      step();
      check("drain steady occupancy", 32'(occ4), 32'd3);
      if (t == 9) iv4 = 1'b0;
      else ins4 = 32'(t);
    end
    for (int t = 0; t < 3; t++) step();
    check("drain empty occupancy", 32'(occ4), 32'd0);
    check("drain pop count", 32'(popped4), 32'd9);

    // Simultaneous push/pop at count 1
    or4 = 1'b0; iv4 = 1'b1; ins4 = 32'hA;
    step();
    ins4 = 32'hB; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    check("simul occupancy", 32'(occ4), 32'd1);
    check("simul outs", outs4, 32'hB);
    step();
    check("simul drained", 32'(occ4), 32'd0);

    // Reset mid-stream
    or4 = 1'b0; iv4 = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      ins4 = 32'h11 * t;
      step();
    end
    check("pre-reset occupancy", 32'(occ4), 32'd3);
    rst = 1'b0; ins4 = 32'h44;
    step();
    rst = 1'b1; iv4 = 1'b0; or4 = 1'b1;
    check("mid reset outs_valid", 32'(ov4), 32'd0);
    check("mid reset occupancy", 32'(occ4), 32'd0);
    check("mid reset ins_ready", 32'(ir4), 32'd1);
    step();
    check("mid reset token discarded", 32'(ov4), 32'd0);

    // Wrap-around on depth 3 with random handshakes
    d = 0; cycles = 0;
    iv3 = 1'b1; ins3 = 32'd0; or3 = 1'($urandom_range(0, 1));
    while (d < 20 && cycles < 600) begin
      #3;
      acc = iv3 && ir3;
      step();
      cycles++;
      if (acc) d++;
      or3 = 1'($urandom_range(0, 1));
      if (!(iv3 && !acc)) begin
        ins3 = 32'(d);
        iv3 = (d < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    iv3 = 1'b0; or3 = 1'b1;
    cycles = 0;
    while (popped3 < 20 && cycles < 100) begin
      step();
      cycles++;
    end
    check("wrap pop count", 32'(popped3), 32'd20);
    check("wrap final occupancy", 32'(occ3), 32'd0);

    step();
    check("dut4 scoreboard empty", 32'(q4.size()), 32'd0);
    check("dut3 scoreboard empty", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
